// File: rtl/exp_result_writer.sv
// exp_result_writer: buffers engine results in a RAM and dumps them over valid/ready; RESULT_PARITY_EN adds a stored even-parity MSB
module exp_result_writer #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int INT_W  = 2,
  parameter int FRAC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              eng_done,
  input  logic [INT_W-1:0]  intpart,
  input  logic [FRAC_W-1:0] fracpart,
  input  logic              rd_start,
  input  logic              out_ready,
  output logic              out_valid,
`ifdef RESULT_PARITY_EN
  output logic [INT_W+FRAC_W:0]   out_data,
`else
  output logic [INT_W+FRAC_W-1:0] out_data,
`endif
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              ovf,
  output logic              dump_done
);
`ifdef RESULT_PARITY_EN
  localparam int DW = INT_W + FRAC_W + 1;
`else
  localparam int DW = INT_W + FRAC_W;
`endif
  localparam logic [ADDR_W:0]   FULL_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_1  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_1  = ADDR_W'(1);
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, FINISH} state_t;
  state_t state, nxt;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] wdata;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic empty_done, wr, last;
`ifdef RESULT_PARITY_EN
  assign wdata = {^{intpart, fracpart}, intpart, fracpart};
`else
  assign wdata = {intpart, fracpart};
`endif
  assign full      = count == FULL_C;
  assign wr        = state == IDLE && eng_done && !full;
  assign last      = {1'b0, rd_ptr} == count - CNT_1;
  assign out_valid = state == PRESENT;
  assign out_addr  = rd_ptr;
  assign dump_done = state == FINISH || empty_done;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = rd_start && (count != '0 || wr) ? FETCH : IDLE;
      FETCH:   nxt = PRESENT;
      PRESENT: nxt = out_ready ? (last ? FINISH : FETCH) : PRESENT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end
  always_ff @(posedge clk) begin
    if (rst && wr) mem[wr_ptr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      empty_done <= 1'b0;
      out_data   <= '0;
    end else begin
      empty_done <= state == IDLE && rd_start && count == '0 && !wr;
      if (eng_done && !wr) ovf <= 1'b1;
      if (wr) begin
        wr_ptr <= wr_ptr + PTR_1;
        count  <= count + CNT_1;
      end
      if (state == IDLE && nxt == FETCH) rd_ptr <= '0;
      if (state == FETCH) out_data <= mem[rd_ptr];
      if (state == PRESENT && out_ready && !last) rd_ptr <= rd_ptr + PTR_1;
      if (state == FINISH) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_exp_result_writer.sv
// tb_exp_result_writer: randomized scoreboard bench for exp_result_writer (DEPTH=4), parity-aware under RESULT_PARITY_EN
module tb_exp_result_writer;
  localparam int AW = 8, DEPTH = 4, IW = 2, FW = 16;
`ifdef RESULT_PARITY_EN
  localparam int DW = IW + FW + 1;
`else
  localparam int DW = IW + FW;
`endif
  logic clk = 1'b0, rst = 1'b0, eng_done = 1'b0, rd_start = 1'b0, out_ready = 1'b0;
  logic [IW-1:0] intpart = '0;
  logic [FW-1:0] fracpart = '0;
  logic out_valid, full, ovf, dump_done;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic [AW:0] count;
  always #5 clk = ~clk;
  exp_result_writer #(.ADDR_W(AW), .DEPTH(DEPTH), .INT_W(IW), .FRAC_W(FW)) dut (
    .clk(clk), .rst(rst), .eng_done(eng_done), .intpart(intpart), .fracpart(fracpart),
    .rd_start(rd_start), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_addr(out_addr), .count(count), .full(full), .ovf(ovf), .dump_done(dump_done)
  );
  typedef struct {logic [DW-1:0] d; int a;} beat_t;
  beat_t exp_q[$];
  logic [DW-1:0] store[$];
  beat_t mb;
  bit ovf_m = 1'b0;
  int exp_dones = 0, done_seen = 0;
  int n_cmp = 0, n_err = 0;
  logic [DW-1:0] hold_d;
  logic [AW-1:0] hold_a;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [DW-1:0] mk(logic [IW-1:0] i, logic [FW-1:0] f);
`ifdef RESULT_PARITY_EN
    return {^{i, f}, i, f};
`else
    return {i, f};
`endif
  endfunction
  function automatic void model_write(logic [IW-1:0] i, logic [FW-1:0] f);
    if (store.size() < DEPTH) store.push_back(mk(i, f));
    else ovf_m = 1'b1;
  endfunction
  function automatic void model_dump();
    beat_t x;
    foreach (store[k]) begin
      x.d = store[k];
      x.a = k;
      exp_q.push_back(x);
    end
    store.delete();
    exp_dones++;
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL beat: unexpected beat addr %0d data %h, none required", out_addr, out_data);
        end else begin
          mb = exp_q.pop_front();
          chk("beat_data", 32'(out_data), 32'(mb.d));
          chk("beat_addr", 32'(out_addr), mb.a);
        end
      end
      if (dump_done) done_seen++;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0; out_ready = 1'b0; eng_done = 1'b0; rd_start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    exp_q.delete();
    store.delete();
    ovf_m = 1'b0;
    exp_dones = done_seen;
  endtask
  task automatic write(logic [IW-1:0] i, logic [FW-1:0] f);
    eng_done = 1'b1; intpart = i; fracpart = f;
    tick();
    eng_done = 1'b0;
    model_write(i, f);
  endtask
  task automatic dump(bit ww, logic [IW-1:0] i, logic [FW-1:0] f);
    rd_start = 1'b1;
    if (ww) begin
      eng_done = 1'b1; intpart = i; fracpart = f;
    end
    tick();
    rd_start = 1'b0; eng_done = 1'b0;
    if (ww) model_write(i, f);
    model_dump();
  endtask
  task automatic wait_dump(bit rnd);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || done_seen != exp_dones) && k < 200) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    chk("dump_completes", 32'(k < 200), 32'd1);
    chk("count_cleared", 32'(count), 32'd0);
    chk("full_cleared", 32'(full), 32'd0);
    chk("ovf_model", 32'(ovf), 32'(ovf_m));
  endtask
  initial begin
    int k, n;
    do_reset();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_addr", 32'(out_addr), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_done", 32'(dump_done), 0);
    write(2'd1, 16'h8000);
    write(2'd2, 16'h0001);
    write(2'd0, 16'hFFFF);
    chk("count3", 32'(count), 3);
    chk("vec_word0", 32'(store[0][IW+FW-1:0]), 32'h18000);
    out_ready = 1'b1;
    dump(1'b0, '0, '0);
    wait_dump(1'b0);
    write(2'd3, 16'h1111);
    write(2'd1, 16'h2222);
    out_ready = 1'b0;
    dump(1'b0, '0, '0);
    chk("latency_fetch", 32'(out_valid), 0);
    tick();
    chk("latency_present", 32'(out_valid), 1);
    hold_d = out_data;
    hold_a = out_addr;
    chk("first_data", 32'(out_data), 32'(mk(2'd3, 16'h1111)));
    repeat (5) begin
      tick();
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_data", 32'(out_data), 32'(hold_d));
      chk("stall_addr", 32'(out_addr), 32'(hold_a));
    end
    out_ready = 1'b1;
    wait_dump(1'b0);
    for (int j = 0; j < 5; j++) begin
      write(2'(j), 16'($urandom));
      if (j == 3) chk("full_at_depth", 32'(full), 1);
    end
    chk("full_count", 32'(count), DEPTH);
    chk("ovf_on_drop", 32'(ovf), 1);
    out_ready = 1'b1;
    dump(1'b0, '0, '0);
    wait_dump(1'b0);
    dump(1'b0, '0, '0);
    chk("empty_done_pulse", 32'(dump_done), 1);
    chk("empty_no_valid", 32'(out_valid), 0);
    tick();
    chk("empty_done_single", 32'(dump_done), 0);
    chk("empty_no_valid2", 32'(out_valid), 0);
    wait_dump(1'b0);
    write(2'd1, 16'h0101);
    write(2'd2, 16'h0202);
    write(2'd3, 16'h0303);
    out_ready = 1'b1;
    dump(1'b0, '0, '0);
    k = 0;
    while (!(out_valid && out_addr == 1) && k < 20) begin
      tick();
      k++;
    end
    chk("reach_beat2", 32'(k < 20), 1);
    rst = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b1;
    exp_q.delete(); store.delete(); ovf_m = 1'b0; exp_dones = done_seen;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_ovf", 32'(ovf), 0);
    write(2'd2, 16'hABCD);
    out_ready = 1'b1;
    dump(1'b0, '0, '0);
    wait_dump(1'b0);
    write(2'd3, 16'h0001);
    write(2'd0, 16'h0003);
    out_ready = 1'b0;
    dump(1'b0, '0, '0);
    eng_done = 1'b1; intpart = 2'd1; fracpart = 16'h5555;
    tick();
    eng_done = 1'b0;
    ovf_m = 1'b1;
    chk("ovf_busy_drop", 32'(ovf), 1);
    chk("no_write_busy", 32'(count), 2);
    out_ready = 1'b1;
    wait_dump(1'b0);
    do_reset();
    repeat (40) begin
      n = $urandom_range(0, 6);
      for (int j = 0; j < n; j++) begin
        write(2'($urandom), 16'($urandom));
        if ($urandom_range(0, 2) == 0) tick();
      end
      chk("rand_count", 32'(count), 32'(store.size()));
      chk("rand_full", 32'(full), 32'(store.size() == DEPTH));
      chk("rand_ovf", 32'(ovf), 32'(ovf_m));
      dump(1'($urandom), 2'($urandom), 16'($urandom));
      if (exp_q.size() != 0 && $urandom_range(0, 3) == 0) begin
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        ovf_m = 1'b1;
      end
      wait_dump(1'b1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
